// File: rtl/qb_seq_pkg.sv
// Shared definitions for the layer sequencer: FSM state encoding, default
// parameter values and a saturating increment used by its counters.
package qb_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    START   = 3'd2,
    WAIT    = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_e;

  localparam int N_LAYERS_DEF = 3;
  localparam int TIMEOUT_DEF  = 1024;
  localparam int CNT_W_DEF    = 16;

  // Callers pass the counter zero-extended and its all-ones value, then cast back.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic [63:0] max_val);
    if (val >= max_val) begin
      return max_val;
    end else begin
      return val + 64'd1;
    end
  endfunction

endpackage

// File: rtl/qb_seq_watchdog.sv
// Per-layer watchdog: cleared by load_i, counts while inc_i, and flags expiry
// once TIMEOUT_CYCLES-1 is reached (it then holds there).
module qb_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    if (load_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/qb_layer_sequencer.sv
// Per-sample controller for the quantised conv network: shift inputs, then run
// each layer start/wait/capture in turn. Define QB_SEQ_PROFILE_EN for frame-length profiling.
module qb_layer_sequencer
  import qb_seq_pkg::*;
#(
  parameter int N_LAYERS       = N_LAYERS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int CNT_W          = CNT_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_clk,
  input  logic [N_LAYERS-1:0]           layer_done,
  output logic                          lsb_shift,
  output logic [N_LAYERS-1:0]           layer_start,
  output logic [N_LAYERS-1:0]           cache_capture,
  output logic                          busy,
  output logic [$clog2(N_LAYERS):0]     layer_idx,
  output logic                          frame_done,
  output logic [CNT_W-1:0]              overrun_count,
  output logic                          timeout_err,
  output logic [$clog2(N_LAYERS):0]     timeout_layer,
  output logic [CNT_W-1:0]              last_frame_cycles,
  output logic [CNT_W-1:0]              max_frame_cycles
);

  localparam int IDX_W = $clog2(N_LAYERS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LAYERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  overrun_q, overrun_d;
  logic              terr_q, terr_d;
  logic [IDX_W-1:0]  tlayer_q, tlayer_d;
  logic              sample_q, armed_q;
  logic              lsb_shift_q, busy_q, frame_done_q;
  logic [N_LAYERS-1:0] start_q, capture_q;

  logic              edge_s, done_sel_s, wd_expired_s, midframe_s;
  logic [CNT_W-1:0]  overrun_inc_s;

  // armed_q masks the first cycle after reset so a high sample_clk is not seen as an edge.
  assign edge_s        = sample_clk & ~sample_q & armed_q;
  assign done_sel_s    = |(layer_done & (N_LAYERS'(1'b1) << idx_q));
  assign midframe_s    = (state_q == SHIFT) || (state_q == START) ||
                         (state_q == WAIT)  || (state_q == CAPTURE);
  assign overrun_inc_s = CNT_W'(sat_inc(64'(overrun_q), 64'(CNT_MAX)));

  qb_seq_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == START),
    .inc_i     (state_q == WAIT),
    .expired_o (wd_expired_s)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    terr_d    = terr_q;
    tlayer_d  = tlayer_q;
    // A new sample always restarts the frame, even over a pending watchdog expiry.
    if (edge_s) begin
      state_d = SHIFT;
      if (midframe_s) begin
        overrun_d = overrun_inc_s;
      end else begin
        overrun_d = overrun_q;
      end
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        SHIFT: begin
          state_d = START;
          idx_d   = '0;
        end
        START:   state_d = WAIT;
        WAIT: begin
          if (done_sel_s) begin
            state_d = CAPTURE;
          end else if (wd_expired_s) begin
            state_d  = IDLE;
            terr_d   = 1'b1;
            tlayer_d = idx_q;
          end else begin
            state_d = WAIT;
          end
        end
        CAPTURE: begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            state_d = START;
            idx_d   = idx_q + IDX_W'(1'b1);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Pulse outputs are decoded from the next state so each is high exactly while in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      overrun_q    <= '0;
      terr_q       <= 1'b0;
      tlayer_q     <= '0;
      sample_q     <= 1'b0;
      armed_q      <= 1'b0;
      lsb_shift_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      start_q      <= '0;
      capture_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      overrun_q    <= overrun_d;
      terr_q       <= terr_d;
      tlayer_q     <= tlayer_d;
      sample_q     <= sample_clk;
      armed_q      <= 1'b1;
      lsb_shift_q  <= (state_d == SHIFT);
      busy_q       <= (state_d != IDLE);
      frame_done_q <= (state_d == DONE);
      start_q      <= (state_d == START)   ? (N_LAYERS'(1'b1) << idx_d) : '0;
      capture_q    <= (state_d == CAPTURE) ? (N_LAYERS'(1'b1) << idx_d) : '0;
    end
  end

  assign lsb_shift     = lsb_shift_q;
  assign layer_start   = start_q;
  assign cache_capture = capture_q;
  assign busy          = busy_q;
  assign layer_idx     = idx_q;
  assign frame_done    = frame_done_q;
  assign overrun_count = overrun_q;
  assign timeout_err   = terr_q;
  assign timeout_layer = tlayer_q;

`ifdef QB_SEQ_PROFILE_EN
  logic [CNT_W-1:0] fcnt_q, last_q, max_q;
  logic [CNT_W-1:0] fcnt_inc_s;

  assign fcnt_inc_s = CNT_W'(sat_inc(64'(fcnt_q), 64'(CNT_MAX)));

  // The count covers SHIFT through DONE; only a frame reaching DONE publishes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      last_q <= '0;
      max_q  <= '0;
    end else begin
      if (state_d == SHIFT) begin
        fcnt_q <= CNT_W'(1'b1);
      end else if (state_d != IDLE) begin
        fcnt_q <= fcnt_inc_s;
      end else begin
        fcnt_q <= fcnt_q;
      end
      if (state_q == DONE) begin
        last_q <= fcnt_q;
        max_q  <= (fcnt_q > max_q) ? fcnt_q : max_q;
      end else begin
        last_q <= last_q;
        max_q  <= max_q;
      end
    end
  end

  assign last_frame_cycles = last_q;
  assign max_frame_cycles  = max_q;
`else
  assign last_frame_cycles = '0;
  assign max_frame_cycles  = '0;
`endif

endmodule

// File: tb/tb_qb_layer_sequencer.sv
// Bench for qb_layer_sequencer: a planned frame schedule feeds an event scoreboard
// and timed status checks, followed by a directed async-reset scenario.
`timescale 1ns/1ps
module tb_qb_layer_sequencer;

  localparam int N    = 3;
  localparam int T    = 8;
  localparam int CW   = 4;
  localparam int IW   = 3;
  localparam int SAT  = 15;
  localparam int MAXC = 4000;
  localparam int EV_SHIFT = 0, EV_START = 1, EV_CAP = 2, EV_DONE = 3;

  logic          clk = 1'b0, rst_n = 1'b0, sample_clk = 1'b0;
  logic [N-1:0]  layer_done = '0;
  logic          lsb_shift, busy, frame_done, timeout_err;
  logic [N-1:0]  layer_start, cache_capture;
  logic [IW-1:0] layer_idx, timeout_layer;
  logic [CW-1:0] overrun_count, last_frame_cycles, max_frame_cycles;

  qb_layer_sequencer #(.N_LAYERS(N), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .layer_done(layer_done),
    .lsb_shift(lsb_shift), .layer_start(layer_start), .cache_capture(cache_capture),
    .busy(busy), .layer_idx(layer_idx), .frame_done(frame_done),
    .overrun_count(overrun_count), .timeout_err(timeout_err), .timeout_layer(timeout_layer),
    .last_frame_cycles(last_frame_cycles), .max_frame_cycles(max_frame_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int layer; int cyc;} ev_t;
  typedef struct {int cyc; int busy; int ovr; int terr; int tlay; int last; int maxv;} st_t;

  ev_t evq[$];
  st_t stq[$];
  logic [N-1:0] fm [MAXC];
  logic [N-1:0] fv [MAXC];
  bit           sc [MAXC];
  int m_ovr, m_terr, m_tlay, m_last, m_max;
  int n_checks = 0, n_errors = 0;
  int cur = -1;
  bit mon_en = 1'b0;
  int s_g;
  st_t mon_st;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cur);
    end
  endtask

  task automatic force_bit(input int c, input int i, input logic v);
    if (c < MAXC) begin
      fm[c][i] = 1'b1;
      fv[c][i] = v;
    end
  endtask

  // Offset from the SHIFT cycle to the last busy cycle (DONE, or last WAIT cycle on timeout).
  function automatic int frame_off(input int d[N]);
    int t = 1;
    for (int i = 0; i < N; i++) begin
      if (d[i] >= T) return t + T;
      t += d[i] + 3;
    end
    return t;
  endfunction

  // Frame starting with SHIFT at cycle s; d[i] = WAIT cycles before layer i's done (>=T: never);
  // e = cycle in which the next sample_clk pulse is driven.
  task automatic plan(input int s, input int d[N], input int e);
    int t, off, bu, to_layer;
    bit to_hit;
    stq.push_back('{s, 1, m_ovr, m_terr, m_tlay, m_last, m_max});
    evq.push_back('{EV_SHIFT, 0, s});
    off = frame_off(d);
    bu = s + off;
    t = s + 1;
    to_hit = 1'b0;
    to_layer = 0;
    for (int i = 0; i < N && !to_hit; i++) begin
      if (t <= e) begin
        evq.push_back('{EV_START, i, t});
        force_bit(t, i, 1'b1);
      end
      if (d[i] >= T) begin
        for (int k = 1; k <= T; k++) if (t + k <= e) force_bit(t + k, i, 1'b0);
        to_hit = 1'b1;
        to_layer = i;
      end else begin
        for (int k = 1; k <= d[i]; k++) if (t + k <= e) force_bit(t + k, i, 1'b0);
        if (t + 1 + d[i] <= e) force_bit(t + 1 + d[i], i, 1'b1);
        if (t + 2 + d[i] <= e) evq.push_back('{EV_CAP, i, t + 2 + d[i]});
        t = t + 3 + d[i];
      end
    end
    if (!to_hit && t <= e) evq.push_back('{EV_DONE, 0, t});
    if (e < bu || (e == bu && to_hit)) begin
      m_ovr = (m_ovr < SAT) ? m_ovr + 1 : SAT;
    end else begin
      if (to_hit) begin
        m_terr = 1;
        m_tlay = to_layer;
      end else begin
`ifdef QB_SEQ_PROFILE_EN
        m_last = (off + 1 > SAT) ? SAT : off + 1;
        if (m_last > m_max) m_max = m_last;
`endif
      end
      if (e > bu) stq.push_back('{bu + 1, 0, m_ovr, m_terr, m_tlay, m_last, m_max});
    end
  endtask

  task automatic add(input int d[N], input int rel);
    int e;
    e = s_g + rel;
    plan(s_g, d, e);
    if (e < MAXC) sc[e] = 1'b1;
    s_g = e + 1;
  endtask

  task automatic observe(input int kind, input int layer);
    ev_t ex;
    if (evq.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: got kind %0d layer %0d, expected none (cycle %0d)", kind, layer, cur);
    end else begin
      ex = evq.pop_front();
      check("event_kind", kind, ex.kind);
      check("event_layer", layer, ex.layer);
      check("event_cycle", cur, ex.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (lsb_shift) observe(EV_SHIFT, 0);
      for (int i = 0; i < N; i++) begin
        if (layer_start[i]) begin
          observe(EV_START, i);
          check("layer_idx", int'(layer_idx), i);
        end
      end
      for (int i = 0; i < N; i++) if (cache_capture[i]) observe(EV_CAP, i);
      if (frame_done) observe(EV_DONE, 0);
      while (stq.size() > 0 && stq[0].cyc == cur) begin
        mon_st = stq.pop_front();
        check("busy", int'(busy), mon_st.busy);
        check("overrun_count", int'(overrun_count), mon_st.ovr);
        check("timeout_err", int'(timeout_err), mon_st.terr);
        check("timeout_layer", int'(timeout_layer), mon_st.tlay);
        check("last_frame_cycles", int'(last_frame_cycles), mon_st.last);
        check("max_frame_cycles", int'(max_frame_cycles), mon_st.maxv);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_lsb_shift"}, int'(lsb_shift), 0);
    check({tag, "_layer_start"}, int'(layer_start), 0);
    check({tag, "_cache_capture"}, int'(cache_capture), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_layer_idx"}, int'(layer_idx), 0);
    check({tag, "_overrun_count"}, int'(overrun_count), 0);
    check({tag, "_timeout_err"}, int'(timeout_err), 0);
    check({tag, "_timeout_layer"}, int'(timeout_layer), 0);
    check({tag, "_last_frame_cycles"}, int'(last_frame_cycles), 0);
    check({tag, "_max_frame_cycles"}, int'(max_frame_cycles), 0);
  endtask

  initial begin
    int d[N];
    int off, rel, s_last, end_cyc;
    for (int c = 0; c < MAXC; c++) begin
      fm[c] = '0;
      fv[c] = '0;
      sc[c] = 1'b0;
    end
    m_ovr = 0; m_terr = 0; m_tlay = 0; m_last = 0; m_max = 0;

    #3;
    check_all_zero("reset");

    // Schedule: first sample pulse in cycle 3, so the first SHIFT is cycle 4.
    sc[3] = 1'b1;
    s_g = 4;
    d = '{0, 0, 0};     add(d, 13);      // minimum-length frame
    d = '{5, 0, 0};     add(d, 18);      // layer 0 waits 5 cycles, stale done in START
    d = '{0, T, 0};     add(d, 16);      // layer 1 times out
    d = '{0, 0, 0};     add(d, 13);      // normal frame after timeout
    d = '{6, 0, 0};     add(d, 6);       // overrun 4 cycles into WAIT of layer 0
    d = '{0, 0, 0};     add(d, 10);      // edge lands in DONE
    d = '{0, 0, 0};     add(d, 13);
    d = '{T, 0, 0};     add(d, 1 + T);   // edge coincides with watchdog expiry
    d = '{0, T - 1, 2}; add(d, frame_off(d) + 2);
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 7) == 0) ? T : int'($urandom_range(0, 6));
      off = frame_off(d);
      if ($urandom_range(0, 3) == 0) rel = int'($urandom_range(1, off));
      else rel = off + int'($urandom_range(1, 4));
      add(d, rel);
    end
    for (int k = 0; k < 18; k++) begin
      d = '{1, 0, 2};
      add(d, 1 + (k % 9));               // repeated overruns drive the counter to saturation
    end
    d = '{0, 0, 0};
    s_last = s_g;
    plan(s_g, d, MAXC + 1000);
    end_cyc = s_last + frame_off(d) + 4;

    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c <= end_cyc; c++) begin
      @(posedge clk);
      #1;
      cur = c;
      sample_clk = sc[c];
      layer_done = (N'($urandom) & ~fm[c]) | (fv[c] & fm[c]);
      mon_en = 1'b1;
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    check("events_left", evq.size(), 0);
    check("status_left", stq.size(), 0);

    // Async reset mid-WAIT with sample_clk held high.
    layer_done = '0;
    sample_clk = 1'b0;
    @(posedge clk); #1;
    sample_clk = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("post_reset_busy", int'(busy), 0);
      check("post_reset_lsb_shift", int'(lsb_shift), 0);
    end
    sample_clk = 1'b0;
    @(posedge clk); #1;
    sample_clk = 1'b1;
    @(posedge clk); #1;
    check("restart_lsb_shift", int'(lsb_shift), 1);
    check("restart_busy", int'(busy), 1);
    check("restart_overrun_count", int'(overrun_count), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
